// File: rtl/quad_decoder_pkg.sv
// Shared types and defaults for the rotary quadrature decoder.
// Detent FSM encodings, result width and parameter defaults live here.
package quad_decoder_pkg;

  localparam int RES_W          = 5;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int MAX_VAL_DEF    = 31;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6
  } qdec_state_e;

  // Colour channel rotation R -> G -> B -> R; 3 is never produced.
  function automatic logic [1:0] sel_advance(input logic [1:0] cur);
    return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side inputs and value/channel outputs of the quadrature decoder.
// master = stimulus/encoder side, slave = decoder side.
interface quad_decoder_if;
  import quad_decoder_pkg::*;

  logic       ROT_A;
  logic       ROT_B;
  logic       btn;
  res_t       res;
  logic [1:0] sel;
  logic       step;

  modport master (
    output ROT_A, ROT_B, btn,
    input  res, sel, step
  );

  modport slave (
    input  ROT_A, ROT_B, btn,
    output res, sel, step
  );

endinterface

// File: rtl/quad_decoder_deb_filter.sv
// Two-flop synchronizer followed by a debounce filter: the output takes a new
// level only after DEB_CYCLES consecutive synchronized samples disagree with it.
module deb_filter #(
  parameter int   DEB_CYCLES = 16,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {2{RST_VAL}};
      filt_reg <= RST_VAL;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      // Any sample agreeing with the current level restarts the run.
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign dout = filt_reg;

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder front end: debounced quadrature detent counter plus a
// push-button colour selector. Build option: QDEC_WRAP_EN (wrap instead of saturate).
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MAX_VAL    = MAX_VAL_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  quad_decoder_if.slave  bus
);

  localparam res_t       MAX_RES = RES_W'(MAX_VAL);
  // Idle levels: A/B high, button released.
  localparam logic [2:0] DEB_RST = 3'b011;

  logic [2:0] raw_in;
  logic [2:0] filt;

  assign raw_in = {bus.btn, bus.ROT_B, bus.ROT_A};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      deb_filter #(
        .DEB_CYCLES (DEB_CYCLES),
        .RST_VAL    (DEB_RST[gi])
      ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (raw_in[gi]),
        .dout    (filt[gi])
      );
    end
  endgenerate

  logic [1:0]  code;
  logic        btn_filt;
  assign code     = {filt[0], filt[1]};
  assign btn_filt = filt[2];

  qdec_state_e state_reg, state_next;
  res_t        res_reg, res_next;
  logic [1:0]  sel_reg, sel_next;
  logic        step_reg, step_next;
  logic        btn_last_reg;
  logic        inc, dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      res_reg      <= '0;
      sel_reg      <= 2'd0;
      step_reg     <= 1'b0;
      btn_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      res_reg      <= res_next;
      sel_reg      <= sel_next;
      step_reg     <= step_next;
      btn_last_reg <= btn_filt;
    end
  end

  // Detent tracker: only a full CW3/CCW3 -> 11 exit produces a count.
  always_comb begin
    state_next = state_reg;
    inc        = 1'b0;
    dec        = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (code == 2'b01)      state_next = ST_CW1;
        else if (code == 2'b10) state_next = ST_CCW1;
      end
      ST_CW1: begin
        if (code == 2'b00)      state_next = ST_CW2;
        else if (code == 2'b11) state_next = ST_IDLE;
      end
      ST_CW2: begin
        if (code == 2'b10)      state_next = ST_CW3;
        else if (code == 2'b01) state_next = ST_CW1;
      end
      ST_CW3: begin
        if (code == 2'b00) begin
          state_next = ST_CW2;
        end else if (code == 2'b11) begin
          state_next = ST_IDLE;
          inc        = 1'b1;
        end
      end
      ST_CCW1: begin
        if (code == 2'b00)      state_next = ST_CCW2;
        else if (code == 2'b11) state_next = ST_IDLE;
      end
      ST_CCW2: begin
        if (code == 2'b01)      state_next = ST_CCW3;
        else if (code == 2'b10) state_next = ST_CCW1;
      end
      ST_CCW3: begin
        if (code == 2'b00) begin
          state_next = ST_CCW2;
        end else if (code == 2'b11) begin
          state_next = ST_IDLE;
          dec        = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    res_next = res_reg;
    if (inc) begin
      if (res_reg >= MAX_RES) begin
`ifdef QDEC_WRAP_EN
        res_next = '0;
`else
        res_next = MAX_RES;
`endif
      end else begin
        res_next = res_reg + 1'b1;
      end
    end else if (dec) begin
      if (res_reg == '0) begin
`ifdef QDEC_WRAP_EN
        res_next = MAX_RES;
`else
        res_next = '0;
`endif
      end else begin
        res_next = res_reg - 1'b1;
      end
    end
  end

  // A clamped count leaves res untouched, so step stays low.
  assign step_next = (res_next != res_reg);
  assign sel_next  = (btn_filt && !btn_last_reg) ? sel_advance(sel_reg) : sel_reg;

  assign bus.res  = res_reg;
  assign bus.sel  = sel_reg;
  assign bus.step = step_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: detents, boundaries, glitches, button
// bounce, coincident events and mid-rotation reset.
module tb_quad_decoder;
  import quad_decoder_pkg::*;

  localparam int DEB  = 16;
  localparam int HOLD = 2 * DEB;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;
  bit   sel3_seen = 1'b0;
  int   s0;

  quad_decoder_if qif();

  quad_decoder #(
    .DEB_CYCLES (DEB),
    .MAX_VAL    (31)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (qif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (qif.step === 1'b1) step_cnt <= step_cnt + 1;
    if (qif.sel === 2'd3)  sel3_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] %s: observed=%0d expected=%0d ok", $time, tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold_code(input logic a, input logic b, input int n);
    qif.ROT_A = a;
    qif.ROT_B = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic cw_detent();
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b0, 1'b0, HOLD);
    hold_code(1'b1, 1'b0, HOLD);
    hold_code(1'b1, 1'b1, HOLD);
  endtask

  task automatic ccw_detent();
    hold_code(1'b1, 1'b0, HOLD);
    hold_code(1'b0, 1'b0, HOLD);
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b1, 1'b1, HOLD);
  endtask

  task automatic set_btn(input logic v, input int n);
    qif.btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic bouncy_press();
    set_btn(1'b1, 3); set_btn(1'b0, 2); set_btn(1'b1, 4); set_btn(1'b0, 3);
    set_btn(1'b1, HOLD + 8);
    set_btn(1'b0, 3); set_btn(1'b1, 2);
    set_btn(1'b0, HOLD + 8);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_res"},  32'(qif.res),  0);
    check({tag, "_sel"},  32'(qif.sel),  0);
    check({tag, "_step"}, 32'(qif.step), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    qif.ROT_A = 1'b1;
    qif.ROT_B = 1'b1;
    qif.btn   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res",  32'(qif.res),  0);
    check("rst_sel",  32'(qif.sel),  0);
    check("rst_step", 32'(qif.step), 0);
    reset_n = 1'b1;
    repeat (HOLD) @(negedge clk);

    // Single CW detent
    s0 = step_cnt;
    cw_detent();
    check("cw1_res",   32'(qif.res), 1);
    check("cw1_steps", 32'(step_cnt - s0), 1);

    // Upper boundary
    pulse_reset("rst2");
    s0 = step_cnt;
    for (int i = 0; i < 31; i++) cw_detent();
    check("cw31_res",   32'(qif.res), 31);
    check("cw31_steps", 32'(step_cnt - s0), 31);
    s0 = step_cnt;
    cw_detent();
`ifdef QDEC_WRAP_EN
    check("cw_top_res",   32'(qif.res), 0);
    check("cw_top_steps", 32'(step_cnt - s0), 1);
`else
    check("cw_top_res",   32'(qif.res), 31);
    check("cw_top_steps", 32'(step_cnt - s0), 0);
`endif

    // Lower boundary
    pulse_reset("rst3");
    s0 = step_cnt;
    ccw_detent();
`ifdef QDEC_WRAP_EN
    check("ccw_bot_res",   32'(qif.res), 31);
    check("ccw_bot_steps", 32'(step_cnt - s0), 1);
`else
    check("ccw_bot_res",   32'(qif.res), 0);
    check("ccw_bot_steps", 32'(step_cnt - s0), 0);
`endif

    // Mixed directions: 0 -> 1 -> 2 -> 1
    pulse_reset("rst4");
    s0 = step_cnt;
    cw_detent();
    cw_detent();
    ccw_detent();
    check("mix_res",   32'(qif.res), 1);
    check("mix_steps", 32'(step_cnt - s0), 3);

    // Short glitches on A and an aborted partial sequence
    s0 = step_cnt;
    for (int i = 0; i < 4; i++) begin
      hold_code(1'b0, 1'b1, DEB - 1);
      hold_code(1'b1, 1'b1, 6);
    end
    hold_code(1'b1, 1'b1, HOLD);
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b0, 1'b0, HOLD);
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b1, 1'b1, HOLD);
    check("glitch_res",   32'(qif.res), 1);
    check("glitch_steps", 32'(step_cnt - s0), 0);

    // Button presses with bounce
    bouncy_press();
    check("btn1_sel", 32'(qif.sel), 1);
    bouncy_press();
    check("btn2_sel", 32'(qif.sel), 2);
    bouncy_press();
    check("btn3_sel", 32'(qif.sel), 0);
    check("btn_res",  32'(qif.res), 1);

    // Button press landing in the same cycle as a CW count
    s0 = step_cnt;
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b0, 1'b0, HOLD);
    hold_code(1'b1, 1'b0, HOLD);
    qif.btn = 1'b1;
    hold_code(1'b1, 1'b1, HOLD);
    check("coin_sel",   32'(qif.sel), 1);
    check("coin_res",   32'(qif.res), 2);
    check("coin_steps", 32'(step_cnt - s0), 1);
    set_btn(1'b0, HOLD);

    // Reset while sitting in CW2; the rest of that detent must not count
    hold_code(1'b0, 1'b1, HOLD);
    hold_code(1'b0, 1'b0, HOLD);
    pulse_reset("rst_cw2");
    s0 = step_cnt;
    hold_code(1'b0, 1'b0, HOLD);
    hold_code(1'b1, 1'b0, HOLD);
    hold_code(1'b1, 1'b1, HOLD);
    check("post_rst_res",   32'(qif.res), 0);
    check("post_rst_steps", 32'(step_cnt - s0), 0);

    check("sel_never_3", 32'(sel3_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
